hd_line_responder: RTL and testbench



---
 rtl/hd_line_pkg.sv | 23 ++
 rtl/hd_line_driver.sv | 13 +
 rtl/hd_line_responder.sv | 140 ++++++++++++++
 tb/tb_hd_line_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_line_pkg.sv
// Shared definitions for the single-wire half-duplex responder: FSM state
// encoding, idle-line level and a helper that sizes counters.
package hd_line_pkg;

  // Responder protocol phases, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    STOP  = 3'd2,
    TURN  = 3'd3,
    TX    = 3'd4,
    GUARD = 3'd5
  } state_t;

  // The board pulls the shared line high, so an undriven line reads as 1.
  localparam logic LINE_IDLE = 1'b1;

  // Width of a counter that has to hold values 0..max_val (never narrower than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hd_line_driver.sv
// Tristate leaf for the shared line: drives dout when oe is high, otherwise
// releases the wire, and always returns the observed line level on din.
module hd_line_driver (
  input  logic oe,
  input  logic dout,
  inout  wire  line,
  output logic din
);

  assign line = oe ? dout : 1'bz;
  assign din  = line;

endmodule

// File: rtl/hd_line_responder.sv
// Responder end of the single-wire half-duplex link. Receives a start bit,
// DW data bits MSB-first and a stop bit, waits TA turnaround cycles, drives a
// DW-bit response MSB-first on the same wire, then releases it for one guard
// cycle before listening again.
module hd_line_responder
  import hd_line_pkg::*;
#(
  parameter int              DW         = 8,
  parameter int              TA         = 2,
  parameter logic [DW-1:0]   RESET_RESP = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  inout  wire           line,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_load,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          busy,
  output logic          drive
);

  // Bit counter spans 0..DW, turnaround counter spans 0..TA-1.
  localparam int BW = cnt_w(DW);
  localparam int TW = cnt_w(TA);

  localparam logic [BW-1:0] DW_CNT  = BW'(DW);
  localparam logic [BW-1:0] DW_LAST = BW'(DW - 1);
  localparam logic [TW-1:0] TA_LAST = TW'(TA - 1);

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] ta_cnt;
  logic [DW-1:0] rx_shift;
  logic [DW-1:0] tx_shift;
  logic [DW-1:0] resp_reg;
  logic          dout;
  logic          din;

  hd_line_driver u_driver (
    .oe   (drive),
    .dout (dout),
    .line (line),
    .din  (din)
  );

  // Response register: local logic may reload it at any time, including mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_reg <= RESET_RESP;
    end else if (tx_load) begin
      resp_reg <= tx_data;
    end
  end

  // Frame FSM with shifters and counters; every output leaves this block registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ta_cnt    <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      drive     <= 1'b0;
      dout      <= LINE_IDLE;
    end else begin
      // NOTE: non-blocking updates let every branch read the pre-edge value of
      // the shifters and counters, which is exactly what the frame timing needs.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          // Only a clean 0 is a start bit; X/Z compares unknown and falls through.
          if (din == 1'b0) begin
            state   <= RX;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        RX: begin
          rx_shift <= {rx_shift[DW-2:0], din};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == DW_LAST) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (din == LINE_IDLE) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            // A reload landing on this very edge wins over the stored response.
            tx_shift <= tx_load ? tx_data : resp_reg;
            ta_cnt   <= '0;
            state    <= TURN;
          end else begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        TURN: begin
          ta_cnt <= ta_cnt + 1'b1;
          if (ta_cnt == TA_LAST) begin
            drive    <= 1'b1;
            dout     <= tx_shift[DW-1];
            tx_shift <= tx_shift << 1;
            bit_cnt  <= BW'(1);
            state    <= TX;
          end
        end
        TX: begin
          if (bit_cnt == DW_CNT) begin
            drive <= 1'b0;
            dout  <= LINE_IDLE;
            state <= GUARD;
          end else begin
            dout     <= tx_shift[DW-1];
            tx_shift <= tx_shift << 1;
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        GUARD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          drive <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd_line_responder.sv
// Scoreboard bench for hd_line_responder. Three responders with TA = 2, 1, 4
// each get the same style of traffic from their own initiator model; expected
// receptions, frame errors and response frames are queued by the stimulus and
// consumed by a per-instance monitor that watches the DUT outputs.
module tb_hd_line_responder;

  localparam int            DW       = 8;
  localparam int            NI       = 3;
  localparam logic [DW-1:0] RST_RESP = 8'hC3;

  typedef struct {
    int            edge_n;
    logic [DW-1:0] data;
  } rx_exp_t;

  typedef struct {
    int            start;
    logic [DW-1:0] val;
    int            nbits;
  } tx_exp_t;

  function automatic int ta_of(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
  endfunction

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc reads n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int ta, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL ta=%0d %s: got %0h expected %0h (edge %0d)", ta, name, act, exp, cyc);
    end
  endtask

  genvar g;
  for (g = 0; g < NI; g++) begin : gi
    localparam int TA_G = ta_of(g);

    wire           line;
    logic          rst_n;
    logic          init_oe;
    logic          init_bit;
    logic          tx_load;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
    logic          drive;

    pullup (line);
    assign line = init_oe ? init_bit : 1'bz;

    hd_line_responder #(
      .DW         (DW),
      .TA         (TA_G),
      .RESET_RESP (RST_RESP)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .line      (line),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy),
      .drive     (drive)
    );

    rx_exp_t       rx_q[$];
    int            err_q[$];
    tx_exp_t       tx_q[$];
    logic [DW-1:0] resp_m;
    logic [DW-1:0] last_rx;

    // Initiator model: called at a falling edge, puts the start bit up for the
    // next rising edge, and follows the frame until the responder is idle again.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop,
                              input bit ld_stop, input logic [DW-1:0] ld_val,
                              input bit ld_tx, input logic [DW-1:0] tx_val,
                              input bit abort, input bit guard_start);
      int      k, t_first, t_guard, t_idle;
      tx_exp_t te;
      k       = cyc + 1;
      t_first = k + DW + 1 + TA_G;
      t_guard = k + 2 * DW + 1 + TA_G;
      t_idle  = t_guard + 1;
      tx_load  = 1'b0;
      init_oe  = 1'b1;
      init_bit = 1'b0;
      for (int i = DW - 1; i >= 0; i--) begin
        @(negedge clk);
        init_bit = d[i];
      end
      @(negedge clk);
      init_bit = stop;
      if (ld_stop) begin
        tx_load = 1'b1;
        tx_data = ld_val;
        resp_m  = ld_val;
      end
      if (stop) begin
        rx_q.push_back('{edge_n: k + DW + 1, data: d});
        te.start = t_first;
        te.val   = resp_m;
        te.nbits = abort ? 2 : DW;
        tx_q.push_back(te);
        last_rx = d;
      end else begin
        err_q.push_back(k + DW + 1);
      end
      @(negedge clk);
      init_oe = 1'b0;
      tx_load = 1'b0;
      if (!stop) begin
        check(TA_G, "busy_after_bad_stop", 32'(busy), 32'd0);
        check(TA_G, "drive_after_bad_stop", 32'(drive), 32'd0);
        check(TA_G, "rx_data_kept", 32'(rx_data), 32'(last_rx));
        return;
      end
      while (cyc < t_idle) begin
        @(negedge clk);
        tx_load = 1'b0;
        init_oe = 1'b0;
        if (abort && cyc == t_first + 1) rst_n = 1'b0;
        if (abort && cyc == t_first + 2) begin
          check(TA_G, "drive_at_reset", 32'(drive), 32'd0);
          check(TA_G, "busy_at_reset", 32'(busy), 32'd0);
          check(TA_G, "rx_data_at_reset", 32'(rx_data), 32'd0);
          rst_n   = 1'b1;
          resp_m  = RST_RESP;
          last_rx = '0;
          return;
        end
        if (ld_tx && cyc == t_first + 3) begin
          tx_load = 1'b1;
          tx_data = tx_val;
          resp_m  = tx_val;
        end
        if (cyc == t_guard) begin
          check(TA_G, "busy_in_guard", 32'(busy), 32'd1);
          check(TA_G, "drive_in_guard", 32'(drive), 32'd0);
          if (guard_start) begin
            init_oe  = 1'b1;
            init_bit = 1'b0;
          end
        end
        if (cyc == t_idle) begin
          check(TA_G, "busy_at_idle", 32'(busy), 32'd0);
          check(TA_G, "drive_at_idle", 32'(drive), 32'd0);
        end
      end
    endtask

    // Stimulus: reset, quiet line, directed corner frames, then random traffic.
    initial begin
      int gap;
      int mode;
      bit stop, ld_stop, ld_tx, abort, gs;
      rst_n    = 1'b0;
      init_oe  = 1'b0;
      init_bit = 1'b1;
      tx_load  = 1'b0;
      tx_data  = '0;
      resp_m   = RST_RESP;
      last_rx  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check(TA_G, "reset_busy", 32'(busy), 32'd0);
      check(TA_G, "reset_drive", 32'(drive), 32'd0);
      check(TA_G, "reset_rx_data", 32'(rx_data), 32'd0);
      check(TA_G, "reset_rx_valid", 32'(rx_valid), 32'd0);
      check(TA_G, "reset_frame_err", 32'(frame_err), 32'd0);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        check(TA_G, "idle_busy", 32'(busy), 32'd0);
        check(TA_G, "idle_drive", 32'(drive), 32'd0);
        check(TA_G, "idle_rx_data", 32'(rx_data), 32'd0);
      end

      tx_load = 1'b1;
      tx_data = 8'hA5;
      resp_m  = 8'hA5;
      @(negedge clk);
      tx_load = 1'b0;
      tx_data = 8'h00;
      send_frame(8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h11, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hFF, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      send_frame(8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          tx_load = 1'b1;
          tx_data = DW'($urandom);
          resp_m  = tx_data;
          @(negedge clk);
          tx_load = 1'b0;
        end
        tx_data = DW'($urandom);
        mode    = $urandom_range(0, 9);
        abort   = (mode == 0);
        ld_tx   = (mode == 1 || mode == 2);
        stop    = ($urandom_range(0, 4) != 0);
        ld_stop = ($urandom_range(0, 3) == 0);
        gs      = ($urandom_range(0, 1) == 1);
        send_frame(DW'($urandom), stop, ld_stop, DW'($urandom),
                   ld_tx, DW'($urandom), abort, gs);
      end

      repeat (5) @(negedge clk);
      check(TA_G, "rx_q_left", 32'(rx_q.size()), 32'd0);
      check(TA_G, "err_q_left", 32'(err_q.size()), 32'd0);
      check(TA_G, "tx_q_left", 32'(tx_q.size()), 32'd0);
      done_cnt++;
    end

    bit            tx_act = 1'b0;
    int            tx_n;
    int            tx_t0;
    logic [DW-1:0] tx_w;
    rx_exp_t       re;
    tx_exp_t       me;
    int            ee;

    // Monitor: every DUT event is matched against the oldest queued expectation.
    always @(negedge clk) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          check(TA_G, "rx_valid_unexpected", 32'd1, 32'd0);
        end else begin
          re = rx_q.pop_front();
          check(TA_G, "rx_data", 32'(rx_data), 32'(re.data));
          check(TA_G, "rx_valid_edge", 32'(cyc), 32'(re.edge_n));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          check(TA_G, "frame_err_unexpected", 32'd1, 32'd0);
        end else begin
          ee = err_q.pop_front();
          check(TA_G, "frame_err_edge", 32'(cyc), 32'(ee));
        end
      end
      if (drive) begin
        if (!tx_act) begin
          tx_act = 1'b1;
          tx_n   = 0;
          tx_t0  = cyc;
          tx_w   = '0;
        end
        tx_w = {tx_w[DW-2:0], line};
        tx_n++;
      end else if (tx_act) begin
        tx_act = 1'b0;
        if (tx_q.size() == 0) begin
          check(TA_G, "tx_unexpected", 32'd1, 32'd0);
        end else begin
          me = tx_q.pop_front();
          check(TA_G, "tx_start_edge", 32'(tx_t0), 32'(me.start));
          check(TA_G, "tx_bit_count", 32'(tx_n), 32'(me.nbits));
          check(TA_G, "tx_value", 32'(tx_w), 32'(me.val >> (DW - me.nbits)));
        end
      end
    end
  end

  // Wait for every instance to finish, bounded so the run always ends.
  initial begin
    for (int i = 0; i < 20000 && done_cnt < NI; i++) @(posedge clk);
    if (done_cnt < NI) check(0, "timeout_instances_done", 32'(done_cnt), 32'(NI));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
